// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic        lzb;
    } disp_t;

endpackage

// File: rtl/ssd_hex_decoder.sv
// Nibble to active-low segment decode with a forced-blank override.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : HEX_SEG[nibble];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller with per-slot blanking and
// frame-synchronous commit of double-buffered display contents.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int PRESCALE  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        LOAD,
    input  logic [15:0] DATA,
    input  logic [3:0]  DP_IN,
    input  logic        LZB,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [1:0]  CONTROL,
    output logic        FRAME,
    output logic        PENDING
);

    localparam int TW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int DW = $clog2(NUM_DIGITS);

    logic [TW-1:0] tick_cnt;
    logic [DW-1:0] digit;
    state_t        state;
    disp_t         shadow;
    disp_t         active;

    logic       slot_end;
    logic       commit_pt;
    logic       do_commit;
    logic       lz_blank;
    logic [3:0] nibble;
    logic [6:0] dec_seg;

    assign slot_end  = (tick_cnt == TW'(PRESCALE - 1));
    assign commit_pt = EN && (digit == DW'(NUM_DIGITS - 1)) && slot_end;
    // A disabled display has no frame to tear, so a pending load lands at once.
    assign do_commit = PENDING && (commit_pt || !EN);
    assign nibble    = active.data[{digit, 2'b00} +: 4];

    always_comb begin
        lz_blank = 1'b0;
        case (digit)
            2'd3:    lz_blank = (active.data[15:12] == '0);
            2'd2:    lz_blank = (active.data[15:8]  == '0);
            2'd1:    lz_blank = (active.data[15:4]  == '0);
            default: lz_blank = 1'b0;
        endcase
        lz_blank = lz_blank & active.lzb;
    end

    ssd_hex_decoder u_dec (
        .nibble (nibble),
        .blank  (lz_blank),
        .seg    (dec_seg)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0;
            digit    <= '0;
            state    <= ST_BLANK;
            shadow   <= '0;
            active   <= '0;
            AN       <= AN_OFF;
            SEG      <= SEG_BLANK;
            DP       <= 1'b1;
            CONTROL  <= '0;
            FRAME    <= 1'b0;
            PENDING  <= 1'b0;
        end else begin
            // A load on the commit cycle stays in the shadow for the next frame.
            if (LOAD) begin
                shadow  <= '{data: DATA, dp: DP_IN, lzb: LZB};
                PENDING <= 1'b1;
            end else if (do_commit) begin
                PENDING <= 1'b0;
            end
            if (do_commit)
                active <= shadow;

            FRAME   <= commit_pt;
            CONTROL <= digit;

            if (!EN) begin
                tick_cnt <= '0;
                digit    <= '0;
                state    <= ST_BLANK;
                AN       <= AN_OFF;
                SEG      <= SEG_BLANK;
                DP       <= 1'b1;
            end else begin
                if (slot_end) begin
                    tick_cnt <= '0;
                    digit    <= digit + DW'(1);
                    state    <= ST_BLANK;
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                    if (tick_cnt == TW'(BLANK_CYC - 1))
                        state <= ST_DRIVE;
                end

                if (state == ST_DRIVE) begin
                    AN  <= ~(4'b0001 << digit);
                    SEG <= dec_seg;
                    DP  <= ~active.dp[digit];
                end else begin
                    AN  <= AN_OFF;
                    SEG <= SEG_BLANK;
                    DP  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: frame-position reference model plus directed checks.
module tb_ssd_scan_ctrl;

    localparam int PRESCALE  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME_LEN = 4 * PRESCALE;

    logic        CLK = 1'b0;
    logic        RST, EN, LOAD, LZB;
    logic [15:0] DATA;
    logic [3:0]  DP_IN;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic [1:0]  CONTROL;
    logic        FRAME, PENDING;

    int errs   = 0;
    int checks = 0;

    ssd_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK_CYC(BLANK_CYC)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .DATA(DATA), .DP_IN(DP_IN),
        .LZB(LZB), .AN(AN), .SEG(SEG), .DP(DP), .CONTROL(CONTROL),
        .FRAME(FRAME), .PENDING(PENDING)
    );

    always #5 CLK = ~CLK;

    // Segments lit for each hex digit, as letters a..g.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        string s;
        logic [6:0] r;
        case (n)
            4'h0: s = "abcdef";  4'h1: s = "bc";      4'h2: s = "abdeg";  4'h3: s = "abcdg";
            4'h4: s = "bcfg";    4'h5: s = "acdfg";   4'h6: s = "acdefg"; 4'h7: s = "abc";
            4'h8: s = "abcdefg"; 4'h9: s = "abcdfg";  4'hA: s = "abcefg"; 4'hB: s = "cdefg";
            4'hC: s = "adef";    4'hD: s = "bcdeg";   4'hE: s = "adefg";  default: s = "aefg";
        endcase
        r = 7'h7F;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
        return r;
    endfunction

    // {AN, SEG, DP} for frame position p (p counts clocks since digit 0 tick 0).
    function automatic logic [11:0] model_out(input int p, input logic en,
                                              input logic [15:0] d, input logic [3:0] dpv,
                                              input logic z);
        int dig, tk;
        logic [3:0] an;
        logic [6:0] sg;
        dig = (p / PRESCALE) % 4;
        tk  = p % PRESCALE;
        if (!en || tk < BLANK_CYC) return {4'hF, 7'h7F, 1'b1};
        an = 4'hF;
        an[dig] = 1'b0;
        if (z && dig > 0 && (d >> (4 * dig)) == 16'd0) sg = 7'h7F;
        else sg = seg_of(d[4 * dig +: 4]);
        return {an, sg, ~dpv[dig]};
    endfunction

    int          m_pos;
    logic [15:0] m_act_d, m_sh_d;
    logic [3:0]  m_act_dp, m_sh_dp;
    logic        m_act_z, m_sh_z, m_pend;
    logic [11:0] e_out;
    logic [1:0]  e_ctrl;
    logic        e_frame;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_pos <= 0;
            m_act_d <= '0; m_act_dp <= '0; m_act_z <= 1'b0;
            m_sh_d  <= '0; m_sh_dp  <= '0; m_sh_z  <= 1'b0;
            m_pend  <= 1'b0;
            e_out   <= {4'hF, 7'h7F, 1'b1};
            e_ctrl  <= 2'd0;
            e_frame <= 1'b0;
        end else begin
            e_out   <= model_out(m_pos, EN, m_act_d, m_act_dp, m_act_z);
            e_ctrl  <= 2'((m_pos / PRESCALE) % 4);
            e_frame <= EN && (m_pos == FRAME_LEN - 1);
            if (m_pend && (!EN || m_pos == FRAME_LEN - 1)) begin
                m_act_d <= m_sh_d; m_act_dp <= m_sh_dp; m_act_z <= m_sh_z;
            end
            if (LOAD) begin
                m_sh_d <= DATA; m_sh_dp <= DP_IN; m_sh_z <= LZB;
                m_pend <= 1'b1;
            end else if (m_pend && (!EN || m_pos == FRAME_LEN - 1)) begin
                m_pend <= 1'b0;
            end
            m_pos <= EN ? (m_pos + 1) % FRAME_LEN : 0;
        end
    end

    always @(negedge CLK) begin
        checks++;
        if ({AN, SEG, DP, CONTROL, FRAME, PENDING} !== {e_out, e_ctrl, e_frame, m_pend}) begin
            errs++;
            $display("FAIL model_cmp t=%0t got AN=%b SEG=%b DP=%b CTRL=%0d FRAME=%b PEND=%b exp AN=%b SEG=%b DP=%b CTRL=%0d FRAME=%b PEND=%b",
                     $time, AN, SEG, DP, CONTROL, FRAME, PENDING,
                     e_out[11:8], e_out[7:1], e_out[0], e_ctrl, e_frame, m_pend);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic wait_an(input logic [3:0] target, input int budget, output int n);
        n = 0;
        do begin @(negedge CLK); n++; end while (AN !== target && n < budget);
        if (AN !== target) chk("wait_an_timeout", 16'(AN), 16'(target));
    endtask

    task automatic wait_frame(input int budget, output int n);
        n = 0;
        do begin @(negedge CLK); n++; end while (FRAME !== 1'b1 && n < budget);
        if (FRAME !== 1'b1) chk("wait_frame_timeout", 16'(FRAME), 16'd1);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dpv, input logic z);
        DATA = d; DP_IN = dpv; LZB = z; LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    initial begin
        int n;
        RST = 1'b1; EN = 1'b0; LOAD = 1'b0; DATA = '0; DP_IN = '0; LZB = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_an", 16'(AN), 16'hF);
        chk("rst_seg", 16'(SEG), 16'h7F);
        chk("rst_ctrl_frame_pend_dp", {12'd0, CONTROL, FRAME, PENDING}, 16'd0);
        RST = 1'b0; EN = 1'b1;

        // Blank display, frame period
        wait_an(4'b1110, 40, n);
        chk("zero_seg", 16'(SEG), 16'h40);
        wait_frame(64, n);
        wait_frame(64, n);
        chk("frame_period", 16'(n), 16'(FRAME_LEN));

        // Double-buffered load mid-frame
        repeat (5) @(negedge CLK);
        load(16'h12AF, 4'b0100, 1'b0);
        chk("pending_set", 16'(PENDING), 16'd1);
        wait_frame(64, n);
        wait_an(4'b1110, 40, n); chk("d0_F", 16'(SEG), 16'h0E);
        wait_an(4'b1101, 40, n); chk("d1_A", 16'(SEG), 16'h08);
        wait_an(4'b1011, 40, n); chk("d2_2", 16'(SEG), 16'h24); chk("d2_dp", 16'(DP), 16'd0);
        wait_an(4'b0111, 40, n); chk("d3_1", 16'(SEG), 16'h79); chk("d3_dp", 16'(DP), 16'd1);

        // Leading-zero blanking
        load(16'h0035, 4'b0000, 1'b1);
        wait_frame(64, n);
        wait_an(4'b1110, 40, n); chk("lz_d0_5", 16'(SEG), 16'h12);
        wait_an(4'b1101, 40, n); chk("lz_d1_3", 16'(SEG), 16'h30);
        wait_an(4'b0111, 40, n); chk("lz_d3_blank", 16'(SEG), 16'h7F);
        load(16'h0000, 4'b0000, 1'b1);
        wait_frame(64, n);
        wait_an(4'b1110, 40, n); chk("lz0_d0", 16'(SEG), 16'h40);
        wait_an(4'b1101, 40, n); chk("lz0_d1_blank", 16'(SEG), 16'h7F);

        // LOAD on the commit cycle stays pending across the boundary
        wait_frame(64, n);
        load(16'h4444, 4'b0000, 1'b0);
        repeat (30) @(negedge CLK);
        load(16'h5555, 4'b0000, 1'b0);
        chk("commit_frame", 16'(FRAME), 16'd1);
        chk("commit_pending", 16'(PENDING), 16'd1);
        wait_an(4'b1110, 40, n); chk("old_shadow", 16'(SEG), 16'h19);
        wait_frame(64, n);
        wait_an(4'b1110, 40, n); chk("new_shadow", 16'(SEG), 16'h12);

        // EN low commits at once and darkens the display
        load(16'h0007, 4'b0000, 1'b0);
        EN = 1'b0;
        @(negedge CLK);
        chk("en0_pending", 16'(PENDING), 16'd0);
        repeat (3) @(negedge CLK);
        chk("en0_an", 16'(AN), 16'hF);
        chk("en0_ctrl_frame", {13'd0, CONTROL, FRAME}, 16'd0);
        EN = 1'b1;
        wait_an(4'b1110, 10, n);
        chk("restart_lat", 16'(n), 16'd3);
        chk("restart_seg", 16'(SEG), 16'h78);

        // Asynchronous reset during digit 2
        load(16'h8888, 4'b1111, 1'b0);
        wait_an(4'b1011, 80, n);
        #1 RST = 1'b1;
        #1;
        chk("arst_an", 16'(AN), 16'hF);
        chk("arst_ctrl_pend", {14'd0, CONTROL}, {15'd0, PENDING});
        chk("arst_pend", 16'(PENDING), 16'd0);
        @(negedge CLK);
        RST = 1'b0;
        wait_an(4'b1110, 40, n); chk("arst_zero", 16'(SEG), 16'h40);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            EN    = ($urandom_range(0, 29) != 0);
            DATA  = 16'($urandom) & (($urandom_range(0, 1) != 0) ? 16'h00FF : 16'hFFFF);
            DP_IN = 4'($urandom);
            LZB   = 1'($urandom);
            LOAD  = ($urandom_range(0, 11) == 0);
            @(negedge CLK);
        end
        LOAD = 1'b0;
        @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Time-multiplexed scan controller for the Nexys3 4-digit seven-segment display in the PmodGYRO demo. It sequences the digit anodes, decodes the selected nibble to segments and drives the decimal point. It exports the current digit index on CONTROL so the existing decimal-point selection logic can be driven from it. Host-side updates are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new values.

Parameters:
PRESCALE, 100000, clocks per digit slot (1 kHz per digit at 100 MHz); must be >= 2
BLANK_CYC, 1000, clocks at the start of each slot with all anodes off (anti-ghosting); 1 <= BLANK_CYC < PRESCALE

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
EN  in  1  scan enable; low = display dark, counters held
LOAD  in  1  one-cycle strobe; captures DATA/DP_IN/LZB into shadow
DATA  in  16  four hex nibbles; [3:0] = digit 0 (rightmost)
DP_IN  in  4  per-digit decimal point request, bit n = digit n
LZB  in  1  leading-zero blanking enable
AN  out  4  anodes, active-low; AN[n] = digit n
SEG  out  7  {g,f,e,d,c,b,a}, active-low
DP  out  1  decimal point, active-low
CONTROL  out  2  digit index currently in its slot
FRAME  out  1  one-cycle pulse at end of digit-3 slot
PENDING  out  1  shadow holds an uncommitted load

Behaviour:
- One clock domain (CLK). RST is asynchronous, active-high. All outputs are registered.
- Reset values:
  - AN=4'b1111, SEG=7'h7F, DP=1, CONTROL=0, FRAME=0, PENDING=0.
  - tick_cnt=0, digit=0, FSM=BLANK.
  - Shadow and active registers cleared.
- FSM states BLANK and DRIVE, advanced by tick_cnt (0..PRESCALE-1):
  - BLANK while tick_cnt < BLANK_CYC; DRIVE otherwise.
  - At tick_cnt=PRESCALE-1: tick_cnt wraps to 0, digit increments mod 4 (3->0), FSM returns to BLANK.
- Output timing: outputs reflect the counter/FSM state of the previous clock (1-cycle latency).
  - BLANK: AN=1111, SEG=7'h7F, DP=1.
  - DRIVE: AN has only bit `digit` low; SEG = decode(active nibble[digit]); DP = ~active_dp[digit].
  - CONTROL = digit, in both phases.
- Hex decode, 0-F standard. Examples: 0 -> 7'b1000000, 8 -> 7'b0000000, A -> 7'b0001000, F -> 7'b0001110.
- Leading-zero blanking (active LZB=1):
  - digit 3 blanked if nibble3==0.
  - digit 2 blanked if nibbles 3 and 2 are both 0.
  - digit 1 blanked if nibbles 3, 2 and 1 are all 0.
  - digit 0 is never blanked.
  - A blanked digit drives SEG=7'h7F and its anode stays low. DP is still honoured.
- LOAD:
  - Shadow <= {DATA, DP_IN, LZB}; PENDING=1 from the next cycle.
  - A later LOAD before commit overwrites the shadow (last one wins).
- Commit (EN=1): at the cycle where digit==3 and tick_cnt==PRESCALE-1:
  - If PENDING: active <= shadow, PENDING <= 0.
  - FRAME pulses for that cycle (registered, visible 1 cycle later), whether or not a commit occurred.
- LOAD in the same cycle as the commit point: the new values go to the shadow only, PENDING stays 1, and they commit at the next frame boundary. The previous shadow content is committed in that cycle.
- EN=0:
  - tick_cnt/digit/FSM are held at reset values; AN=1111, SEG=7'h7F, DP=1, FRAME=0.
  - Any pending shadow commits on the next clock, and PENDING clears.
- EN rising: scanning starts at digit 0, BLANK, tick 0.
- RST mid-frame: immediate return to reset values; shadow and active contents are lost.

Decomposition:
- Package ssd_pkg:
  - NUM_DIGITS=4.
  - state enum {ST_BLANK, ST_DRIVE}.
  - SEG_BLANK=7'h7F, AN_OFF=4'hF.
  - 16-entry hex-to-segment constant table.
- Sub-module ssd_hex_decoder: combinational, 4-bit nibble plus blank flag in, 7-bit active-low SEG out. Instantiated once, on the muxed nibble.
- All other logic stays in ssd_scan_ctrl.

Test Plan:
- Reset, PRESCALE=8, BLANK_CYC=2, EN=1, no LOAD -> AN=1111 for ticks 0-1 of each slot; AN=1110,1101,1011,0111 in turn for ticks 2-7; SEG=7'b1000000; FRAME every 32 clocks.
- LOAD DATA=16'h12AF, DP_IN=4'b0100 mid-frame -> PENDING=1, display unchanged until FRAME; next frame SEG for digits 0..3 = F,A,2,1; DP low only in the digit-2 slot.
- LOAD DATA=16'h0035, LZB=1 -> digits 3 and 2 show SEG=7'h7F with their anodes low; digits 1 and 0 show 3 and 5. LOAD DATA=16'h0000, LZB=1 -> only digit 0 shows 0.
- LOAD asserted exactly on the commit cycle with prior PENDING=1 -> the older shadow is committed; the new value appears one frame later; PENDING stays 1 across that boundary.
- EN=0 with PENDING=1 -> AN=1111, PENDING clears in 1 clock, FRAME stays 0; EN=1 -> scan restarts at digit 0 tick 0 with the new data.
- Assert RST during DRIVE of digit 2 -> asynchronous return to AN=1111, CONTROL=0, PENDING=0; after release, digit 0 shows 0.
